// File: rtl/uc_seq.sv
// Control unit and run sequencer for the single-cycle datapath: opcode decode,
// start/halt/trap/single-step run control and a saturating retired-instruction counter.
module uc_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             z,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       op_alu,
  output logic             pc_en,
  output logic             running,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    PAUSE  = 3'd2,
    EXEC1  = 3'd3,
    HALTED = 3'd4,
    TRAP   = 3'd5
  } state_t;

  state_t state, state_next;

  logic is_alu, is_li, is_j, is_jz, is_jnz, is_halt, is_illegal;
  logic exec;

  assign is_alu     = opcode[5];
  assign is_li      = (opcode[5:2] == 4'b0000);
  assign is_j       = (opcode == 6'b000100);
  assign is_jz      = (opcode == 6'b000101);
  assign is_jnz     = (opcode == 6'b000110);
  assign is_halt    = (opcode == 6'b000111);
  assign is_illegal = (opcode[5:3] == 3'b001) || (opcode[5:4] == 2'b01);

  // Reset gates execution combinationally so a pending write is suppressed on the reset edge.
  assign exec = ((state == RUN) || (state == EXEC1)) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (pc_en && (instr_count != {CNT_W{1'b1}}))
        instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    pc_en  = 1'b0;
    we3    = 1'b0;
    wez    = 1'b0;
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    op_alu = 3'b000;
    if (exec) begin
      if (is_alu) begin
        op_alu = opcode[4:2];
        we3    = 1'b1;
        wez    = 1'b1;
        pc_en  = 1'b1;
      end else if (is_li) begin
        s_inm = 1'b1;
        we3   = 1'b1;
        pc_en = 1'b1;
      end else if (is_j) begin
        s_inc = 1'b0;
        pc_en = 1'b1;
      end else if (is_jz) begin
        s_inc = ~z;
        pc_en = 1'b1;
      end else if (is_jnz) begin
        s_inc = z;
        pc_en = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:
        if (start) state_next = step_mode ? PAUSE : RUN;
      RUN:
        if (is_halt)         state_next = HALTED;
        else if (is_illegal) state_next = TRAP;
        else if (step_mode)  state_next = PAUSE;
      PAUSE:
        if (!step_mode) state_next = RUN;
        else if (step)  state_next = EXEC1;
      EXEC1:
        if (is_halt)         state_next = HALTED;
        else if (is_illegal) state_next = TRAP;
        else                 state_next = PAUSE;
      HALTED:  state_next = HALTED;
      TRAP:    state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  assign running = (state == RUN) || (state == EXEC1);
  assign halted  = (state == HALTED);
  assign trap    = (state == TRAP);

endmodule

// File: tb/tb_uc_seq.sv
// Directed bench for uc_seq: run, halt, trap, single-step, branch decode,
// mid-run reset, and counter saturation on a narrow-counter instance.
module tb_uc_seq;

  localparam logic [5:0] OP_LI   = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b100100;
  localparam logic [5:0] OP_J    = 6'b000100;
  localparam logic [5:0] OP_JZ   = 6'b000101;
  localparam logic [5:0] OP_JNZ  = 6'b000110;
  localparam logic [5:0] OP_HALT = 6'b000111;
  localparam logic [5:0] OP_ILL  = 6'b010000;

  // ctl = {pc_en, we3, wez, s_inc, s_inm, op_alu}
  localparam logic [7:0] CTL_IDLE = 8'b0001_0000;

  logic        clk = 1'b0;
  logic        reset, start, step_mode, step, z;
  logic [5:0]  opcode;
  logic        s_inc, s_inm, we3, wez, pc_en, running, halted, trap;
  logic [2:0]  op_alu;
  logic [15:0] instr_count;

  logic        reset_s, start_s;
  logic [5:0]  opcode_s;
  logic        s_inc_s, s_inm_s, we3_s, wez_s, pc_en_s, running_s, halted_s, trap_s;
  logic [2:0]  op_alu_s;
  logic [3:0]  instr_count_s;

  int checks = 0;
  int fails  = 0;

  uc_seq #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .start(start),
    .step_mode(step_mode), .step(step), .s_inc(s_inc), .s_inm(s_inm),
    .we3(we3), .wez(wez), .op_alu(op_alu), .pc_en(pc_en), .running(running),
    .halted(halted), .trap(trap), .instr_count(instr_count)
  );

  uc_seq #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset_s), .opcode(opcode_s), .z(1'b0), .start(start_s),
    .step_mode(1'b0), .step(1'b0), .s_inc(s_inc_s), .s_inm(s_inm_s),
    .we3(we3_s), .wez(wez_s), .op_alu(op_alu_s), .pc_en(pc_en_s), .running(running_s),
    .halted(halted_s), .trap(trap_s), .instr_count(instr_count_s)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ctl();
    return {pc_en, we3, wez, s_inc, s_inm, op_alu};
  endfunction

  function automatic logic [2:0] sts();
    return {running, halted, trap};
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0; z = 1'b0; opcode = OP_LI;
    reset_s = 1'b1; start_s = 1'b0; opcode_s = OP_J;
    tick(2);
    reset = 1'b0;
    #1;
    check_output("reset_ctl", ctl(), CTL_IDLE);
    check_output("reset_sts", sts(), 3'b000);
    check_output("reset_cnt", instr_count, 0);

    // Program: LI / SUB / JZ (z=1) / HALT
    start = 1'b1; #1;
    check_output("idle_ctl", ctl(), CTL_IDLE);
    tick(); start = 1'b0; #1;
    check_output("run_sts", sts(), 3'b100);
    check_output("li_ctl", ctl(), 8'b1101_1000);
    tick(); opcode = OP_SUB; #1;
    check_output("sub_ctl", ctl(), 8'b1111_0001);
    tick(); opcode = OP_JZ; z = 1'b1; #1;
    check_output("jz_taken_ctl", ctl(), 8'b1000_0000);
    tick(); opcode = OP_HALT; #1;
    check_output("halt_ctl", ctl(), CTL_IDLE);
    tick(); #1;
    check_output("halted_sts", sts(), 3'b010);
    check_output("halted_ctl", ctl(), CTL_IDLE);
    check_output("halted_cnt", instr_count, 3);
    start = 1'b1; step = 1'b1; opcode = OP_SUB;
    tick(); start = 1'b0; step = 1'b0; #1;
    check_output("halted_sticky", sts(), 3'b010);
    check_output("halted_ctl2", ctl(), CTL_IDLE);

    // Illegal opcode trap
    reset = 1'b1; tick(); reset = 1'b0; z = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    opcode = OP_ILL; #1;
    check_output("ill_ctl", ctl(), CTL_IDLE);
    tick(); #1;
    check_output("trap_sts", sts(), 3'b001);
    start = 1'b1; tick(); start = 1'b0; step = 1'b1; tick(); step = 1'b0; #1;
    check_output("trap_sticky", sts(), 3'b001);
    check_output("trap_cnt", instr_count, 0);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    check_output("trap_reset_sts", sts(), 3'b000);
    check_output("trap_reset_cnt", instr_count, 0);

    // Single-step: three steps, each one retiring exactly one instruction
    opcode = OP_SUB; step_mode = 1'b1; start = 1'b1;
    tick(); start = 1'b0; #1;
    check_output("pause_ctl", ctl(), CTL_IDLE);
    check_output("pause_sts", sts(), 3'b000);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; tick(); step = 1'b0; #1;
      check_output($sformatf("exec1_ctl_%0d", i), ctl(), 8'b1111_0001);
      check_output($sformatf("exec1_sts_%0d", i), sts(), 3'b100);
      tick(); #1;
      check_output($sformatf("back_pause_%0d", i), {sts(), pc_en}, 4'b0000);
    end
    check_output("step_cnt", instr_count, 3);
    tick(2); #1;
    check_output("pause_hold_cnt", instr_count, 3);
    step_mode = 1'b0; tick(); #1;
    check_output("resume_run_sts", sts(), 3'b100);

    // Branch decode in RUN
    opcode = OP_JNZ; z = 1'b1; #1;
    check_output("jnz_z1_ctl", ctl(), 8'b1001_0000);
    tick(); opcode = OP_JZ; z = 1'b0; #1;
    check_output("jz_z0_ctl", ctl(), 8'b1001_0000);
    tick(); opcode = OP_J; #1;
    check_output("j_ctl", ctl(), 8'b1000_0000);
    tick(); #1;
    check_output("branch_cnt", instr_count, 6);

    // step_mode rising in RUN: current instruction still retires
    opcode = OP_SUB; step_mode = 1'b1; #1;
    check_output("run_to_pause_ctl", ctl(), 8'b1111_0001);
    tick(); #1;
    check_output("run_to_pause_sts", {sts(), pc_en}, 4'b0000);
    check_output("run_to_pause_cnt", instr_count, 7);

    // Reset mid-run with a pending ALU op
    step_mode = 1'b0; tick(); #1;
    check_output("pre_reset_run", sts(), 3'b100);
    reset = 1'b1; #1;
    check_output("midrun_reset_ctl", ctl(), CTL_IDLE);
    tick(); reset = 1'b0; #1;
    check_output("midrun_reset_sts", sts(), 3'b000);
    check_output("midrun_reset_cnt", instr_count, 0);
    check_output("midrun_idle_ctl", ctl(), CTL_IDLE);

    // Narrow counter saturates on a 20-instruction jump loop
    reset_s = 1'b0; start_s = 1'b1; tick(); start_s = 1'b0;
    tick(14); #1;
    check_output("small_cnt_14", instr_count_s, 4'hE);
    tick(6); #1;
    check_output("small_cnt_sat", instr_count_s, 4'hF);
    check_output("small_pc_en", pc_en_s, 1'b1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
